pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Controller that sequences the program counter and the instruction fetch handshake.
- Holds the architectural PC and issues one request per PC to instruction memory.
- Presents the fetched instruction downstream with a valid/ready handshake, then advances the PC by PC_STEP or redirects it to a branch target.
- Produces the one-cycle write-enable pulse and data for the PC/register-file storage that latches the committed PC.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- PC_STEP, 4, sequential PC increment.
- ACK_TIMEOUT, 15, maximum cycles spent waiting for imem_ack before the fault flag is raised; the timeout counter is 4 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  leave IDLE and begin fetching; sampled in IDLE only.
- halt  in  1  finish the current instruction handoff, then return to IDLE.
- branch_valid  in  1  redirect request, single-cycle pulse.
- branch_target  in  XLEN  redirect PC; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  fetch request, held until acknowledged.
- imem_addr  out  XLEN  fetch address; equals pc while imem_req is high.
- imem_ack  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  XLEN  instruction word.
- instr_valid  out  1  instruction available downstream.
- instr_ready  in  1  downstream accepts the instruction.
- instr_out  out  XLEN  registered instruction.
- instr_pc  out  XLEN  PC of instr_out.
- pc_wr_en  out  1  one-cycle commit strobe to the PC/register-file storage.
- pc_wr_data  out  XLEN  committed next PC.
- busy  out  1  state is not IDLE.
- fault  out  1  sticky ack-timeout flag; cleared only by rst.

Behaviour:
- Reset (asynchronous): state=IDLE, pc=RESET_PC, timeout counter=0, flush=0. All outputs are 0, except imem_addr, which shows pc=RESET_PC.
- FSM states are IDLE, REQ, DELIVER and FAULT.
- IDLE:
  - start=1 moves to REQ on the next cycle.
  - branch_valid in IDLE loads pc=branch_target and stays in IDLE.
- REQ:
  - imem_req=1 and imem_addr=pc.
  - On imem_ack: latch instr_out=imem_rdata and instr_pc=pc, then go to DELIVER with instr_valid=1 from the next cycle.
  - Fetch latency is therefore ack cycle + 1.
- Timeout:
  - The counter increments each REQ cycle without ack and resets on ack.
  - On the ACK_TIMEOUT-th consecutive cycle without ack, the FSM moves to FAULT.
  - In FAULT: fault=1, imem_req=0, and the FSM stays there until rst.
- DELIVER:
  - instr_valid=1. instr_out and instr_pc are stable until instr_valid && instr_ready.
  - On handshake: pc ← pc+PC_STEP (wraps modulo 2^XLEN), pc_wr_en=1 for exactly one cycle, pc_wr_data = new pc.
  - After the handshake the FSM goes to REQ, or to IDLE if halt was seen since entering DELIVER.
  - Back-to-back throughput is one instruction per 2 cycles when ack is same-cycle.
- Branch in DELIVER:
  - instr_valid drops in the next cycle; the held instruction is discarded and never handshaken.
  - pc ← branch_target, pc_wr_en pulses with pc_wr_data = branch_target, and the FSM goes to REQ.
  - If instr_ready and branch_valid arrive in the same cycle, the handshake completes and the branch wins the PC update: pc = branch_target, not pc+PC_STEP.
- Branch in REQ without ack:
  - pc and imem_addr switch to branch_target next cycle and imem_req stays high, so the request is retargeted.
  - pc_wr_en pulses and the timeout counter resets.
- Branch in REQ with ack in the same cycle:
  - The acked data is dropped (no DELIVER).
  - pc ← branch_target, pc_wr_en pulses, and the FSM stays in REQ.
- halt in REQ: the outstanding request must complete, then pass through DELIVER, then the FSM enters IDLE. halt in IDLE has no effect.
- Only one commit pulse per cycle. pc_wr_en is never asserted in IDLE, except on an IDLE branch, where it pulses.
- Reset mid-operation: immediate return to reset values; the pending request is abandoned and imem_req=0 asynchronously.
- instr_valid must never drop without a handshake except for branch or rst.

Decomposition:
- Shared package:
  - state enum for IDLE, REQ, DELIVER, FAULT;
  - XLEN and RESET_PC defaults;
  - PC_STEP constant.
- One natural sub-module, pc_next_mux: combinational selection of the next pc (hold / +PC_STEP / branch_target) with priority branch > step > hold.
- The FSM, timeout counter and output registers stay in the top module.

Test Plan:
- Reset then start; memory acks same cycle with rdata=0x11, 0x22, 0x33; instr_ready=1 → instr_pc = 0, 4, 8; pc_wr_data = 4, 8, 12; one pc_wr_en pulse per instruction.
- DELIVER with instr_ready=0 for 5 cycles → instr_out=0x11 stays stable and instr_valid stays 1. Then ready=1 → exactly one pc_wr_en, and pc=4.
- Branch to 0x100 in the same cycle as instr_ready in DELIVER → pc=0x100 (not 4), next imem_addr=0x100, single pc_wr_en with pc_wr_data=0x100.
- Branch to 0x200 while in REQ with ack withheld → imem_addr becomes 0x200 with imem_req continuously high. Branch target 0x203 → 0x200.
- Ack withheld for 15 cycles → fault=1, imem_req=0, busy=1. fault stays at 1 with further traffic until rst, then returns to 0.
- Assert rst while in DELIVER → instr_valid, imem_req and busy go to 0 immediately and pc=RESET_PC. After start, the fetch resumes at address 0.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and defaults for the PC fetch sequencer: FSM states, next-pc
// select codes and the architectural constants.
package pc_fetch_sequencer_pkg;

  localparam int          XLEN_DEF        = 32;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam int          PC_STEP_DEF     = 4;
  localparam int          ACK_TIMEOUT_DEF = 15;
  localparam int          TO_W            = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DELIVER = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_STEP   = 2'd1,
    SEL_BRANCH = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/pc_fetch_sequencer_pc_next_mux.sv
// Next-PC selection: branch target beats sequential step, which beats hold.
// Also flags whether the selected value is a commit to the PC storage.
module pc_next_mux
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic            step_en,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_next,
  output logic            commit
);

  pc_sel_t sel;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel = SEL_HOLD;
    if (branch_valid)  sel = SEL_BRANCH;
    else if (step_en)  sel = SEL_STEP;
  end

  always_comb begin
    pc_next = pc;
    commit  = 1'b0;
    case (sel)
      // Targets are word aligned; the low two bits are dropped, not trapped.
      SEL_BRANCH: begin
        pc_next = {branch_target[XLEN-1:2], 2'b00};
        commit  = 1'b1;
      end
      SEL_STEP: begin
        pc_next = pc + XLEN'(PC_STEP);
        commit  = 1'b1;
      end
      default: begin
        pc_next = pc;
        commit  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: one imem request per PC, valid/ready delivery downstream,
// sequential or branch PC update with a one-cycle commit strobe, ack watchdog.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF),
  parameter int              PC_STEP     = PC_STEP_DEF,
  parameter int              ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            pc_wr_en,
  output logic [XLEN-1:0] pc_wr_data,
  output logic            busy,
  output logic            fault
);

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [TO_W-1:0] to_cnt;
  logic            halt_seen;
  logic            branch_eff;
  logic            step_en;
  logic            commit;
  logic            ack_taken;
  logic            timeout_hit;

  // A fault freezes the sequencer until reset, so redirects are ignored there.
  assign branch_eff  = branch_valid && (state != S_FAULT);
  assign step_en     = (state == S_DELIVER) && instr_ready;
  assign ack_taken   = (state == S_REQ) && imem_ack && !branch_eff;
  assign timeout_hit = (to_cnt == TO_W'(ACK_TIMEOUT - 1));

  pc_next_mux #(
    .XLEN    (XLEN),
    .PC_STEP (PC_STEP)
  ) u_pc_next_mux (
    .pc            (pc),
    .step_en       (step_en),
    .branch_valid  (branch_eff),
    .branch_target (branch_target),
    .pc_next       (pc_next),
    .commit        (commit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_REQ;
      S_REQ: begin
        if (branch_eff)       state_next = S_REQ;
        else if (imem_ack)    state_next = S_DELIVER;
        else if (timeout_hit) state_next = S_FAULT;
      end
      S_DELIVER: begin
        if (branch_eff)       state_next = S_REQ;
        else if (instr_ready) state_next = (halt_seen || halt) ? S_IDLE : S_REQ;
      end
      S_FAULT:   state_next = S_FAULT;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == S_REQ);
    instr_valid = (state == S_DELIVER);
    busy        = (state != S_IDLE);
    fault       = (state == S_FAULT);
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      to_cnt     <= '0;
      halt_seen  <= 1'b0;
      instr_out  <= '0;
      instr_pc   <= '0;
      pc_wr_en   <= 1'b0;
      pc_wr_data <= '0;
    end else begin
      pc       <= pc_next;
      pc_wr_en <= commit;
      if (commit) pc_wr_data <= pc_next;

      // Counts consecutive unacknowledged request cycles; a retarget restarts it.
      if ((state == S_REQ) && !imem_ack && !branch_eff) to_cnt <= to_cnt + 1'b1;
      else                                               to_cnt <= '0;

      if (ack_taken) begin
        instr_out <= imem_rdata;
        instr_pc  <= pc;
      end

      if (state_next == S_IDLE)
        halt_seen <= 1'b0;
      else if (halt && ((state == S_REQ) || (state == S_DELIVER)))
        halt_seen <= 1'b1;
    end
  end

endmodule
